pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Drives the load enables of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, and the bubble/flush controls for the interstage registers.
- Detects load-use hazards between ID and EX and freezes the pipe on cache misses.
- Sequences the two-access LDI/STI indirect in MEM with a small FSM, replacing ad-hoc indirect handling inside the ID_EX register.

Parameters:
- STALL_CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_opcode  in  4  lc3b_opcode of the instruction in ID
- id_sr1  in  3  lc3b_reg, source 1 in ID
- id_sr2  in  3  lc3b_reg, source 2 in ID
- id_sr1_used  in  1  ID instruction reads sr1
- id_sr2_used  in  1  ID instruction reads sr2 (register form only)
- ex_dest  in  3  lc3b_reg, destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load (LDR/LDB/LDI)
- ex_regfile_write  in  1  EX instruction writes the register file
- mem_opcode  in  4  opcode in MEM
- mem_access  in  1  MEM stage is requesting the dcache this cycle
- dcache_resp  in  1  dcache access complete
- icache_resp  in  1  icache fetch complete
- branch_taken  in  1  resolved taken branch/JMP/JSR/TRAP in MEM
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
- bubble_id_ex  out  1  load a NOP control word into ID_EX
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear the register to NOP on its next load
- ind_phase2  out  1  MEM address mux selects the latched indirect pointer
- load_ind_ptr  out  1  latch dcache rdata as the indirect pointer
- stall_cycles, flush_count  out  STALL_CNT_W each  performance counters (optional feature only)

Behaviour:
- All control outputs are combinational from the current state and inputs; the FSM state is the only registered element, apart from the optional counters.
- FSM states: RUN, IND_WAIT2.
- Priority within RUN, highest first:
  1. Cache stall: (mem_access && !dcache_resp) || !icache_resp.
     - All load_* = 0.
     - bubble_id_ex, flush_* = 0.
     - State holds.
  2. Indirect, first access: mem_opcode is LDI or STI, mem_access && dcache_resp.
     - load_ind_ptr = 1.
     - All load_* = 0.
     - Next state IND_WAIT2.
  3. Branch taken: branch_taken = 1.
     - All load_* = 1.
     - flush_if_id = flush_id_ex = flush_ex_mem = 1.
     - Any load-use condition in the same cycle is ignored, because the flush discards it.
  4. Load-use: ex_mem_read && ex_regfile_write && ((id_sr1_used && id_sr1 == ex_dest) || (id_sr2_used && id_sr2 == ex_dest)).
     - load_pc = load_if_id = 0.
     - load_id_ex = 1 with bubble_id_ex = 1.
     - load_ex_mem = load_mem_wb = 1.
     - Exactly one bubble is inserted, since forwarding covers the next cycle.
  5. Otherwise: all load_* = 1; all bubble/flush outputs = 0.
- IND_WAIT2:
  - ind_phase2 = 1 for the whole state.
  - While !dcache_resp || !icache_resp: all load_* = 0.
  - When both responses are high: all load_* = 1, next state RUN.
  - The load-use and branch rules still apply on the release cycle. MEM holds an LDI/STI, which is never a branch.
- An ID instruction that is not a register reader has its id_srX_used inputs low, so it never stalls.
- Latency: the load-use stall is 1 cycle. The indirect costs at least 1 extra cycle beyond both dcache accesses.
- Reset (synchronous):
  - While reset is high: all load_* = 0, flush_* = 1, bubble_id_ex = 0, ind_phase2 = 0, load_ind_ptr = 0.
  - State becomes RUN at the next edge, including from IND_WAIT2 mid-operation; the pending indirect is abandoned.
  - Counters clear to 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cycles increments on every cycle where load_pc = 0 and reset is low.
  - flush_count increments on each cycle with branch_taken acted on (priority 3).
  - Both counters saturate at all-ones and do not wrap.
- When undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- lc3b_types holds lc3b_opcode (op_ldi, op_sti), lc3b_reg, and a new enum hazard_state_t {RUN, IND_WAIT2}.
- Add a constant for the NOP control word there, for use by the bubble/flush logic in the stage registers.
- Natural sub-module: load_use_detect, purely combinational, taking id_sr*/used and ex_* and producing one hazard bit.

Test Plan:
- EX = LDR R2, ID = ADD R3,R2,R1 (id_sr1=2, ex_dest=2, ex_mem_read=1) -> one cycle with load_pc=0, load_if_id=0, bubble_id_ex=1; next cycle all loads 1.
- icache_resp low for 3 cycles -> all load_* = 0 for exactly those 3 cycles, no flush or bubble.
- LDI in MEM: first dcache_resp -> load_ind_ptr=1, loads 0, state IND_WAIT2; dcache_resp again 4 cycles later -> ind_phase2 high throughout, then all loads 1, back to RUN.
- branch_taken=1 in the same cycle as a load-use match -> flush_if_id/id_ex/ex_mem = 1, all loads 1, bubble_id_ex = 0.
- Reset asserted while in IND_WAIT2 -> flushes high, loads 0 during reset; after release state is RUN and ind_phase2 = 0.
- HAZARD_PERF_CNT_EN: 5 stall cycles plus 2 taken branches -> stall_cycles=5, flush_count=2; preload near max -> counters hold at 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Purpose  : Shared LC-3b types for the hazard sequencer and stage registers.
//            - lc3b_opcode    : 4-bit instruction opcode
//            - lc3b_reg       : 3-bit register specifier
//            - hazard_state_t : hazard sequencer states (RUN, IND_WAIT2)
//            - c_NOP_CTRL_WORD: control word loaded by a bubble or a flush
//            - f_is_indirect  : true for the two-access LDI/STI opcodes
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef logic [2:0] lc3b_reg;

    // Explicit 1-bit encoding so the state register width is fixed.
    typedef enum logic [0:0] {
        RUN       = 1'b0,
        IND_WAIT2 = 1'b1
    } hazard_state_t;

    // All-zero control word: no register write, no memory access, no branch.
    // Stage registers substitute this when a bubble or flush is requested.
    localparam logic [15:0] c_NOP_CTRL_WORD = 16'h0000;

    function automatic logic f_is_indirect(input logic [3:0] i_op);
        f_is_indirect = (i_op == op_ldi) || (i_op == op_sti);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_load_use_detect
// Purpose  : Combinational load-use hazard detector between ID and EX.
// Ports    : i_id_sr1/i_id_sr2           ID source registers
//            i_id_sr1_used/i_id_sr2_used ID really reads that source
//            i_ex_dest                   EX destination register
//            i_ex_mem_read               EX is a load
//            i_ex_regfile_write          EX writes the register file
//            o_hazard                    ID needs a value EX has not loaded yet
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  lc3b_reg i_id_sr1,
    input  lc3b_reg i_id_sr2,
    input  logic    i_id_sr1_used,
    input  logic    i_id_sr2_used,
    input  lc3b_reg i_ex_dest,
    input  logic    i_ex_mem_read,
    input  logic    i_ex_regfile_write,
    output logic    o_hazard
);

    logic w_sr1_match;
    logic w_sr2_match;

    assign w_sr1_match = i_id_sr1_used && (i_id_sr1 == i_ex_dest);
    assign w_sr2_match = i_id_sr2_used && (i_id_sr2 == i_ex_dest);
    assign o_hazard    = i_ex_mem_read && i_ex_regfile_write && (w_sr1_match || w_sr2_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage LC-3b pipeline. Produces
//            the stage-register load enables, the ID_EX bubble, the
//            interstage flushes and the LDI/STI two-access sequencing.
// Ports    : clk, reset (sync, active high)
//            id_*   ID opcode/sources      ex_*  EX destination/load info
//            mem_opcode, mem_access        MEM stage dcache request
//            dcache_resp, icache_resp      cache completions
//            branch_taken                  redirect resolved in MEM
//            load_pc..load_mem_wb          register load enables
//            bubble_id_ex, flush_*         NOP insertion controls
//            ind_phase2, load_ind_ptr      indirect pointer handling
//            stall_cycles, flush_count     performance counters
// Options  : HAZARD_PERF_CNT_EN - build the saturating performance counters;
//            when undefined the counter ports read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             id_opcode,
    input  logic [2:0]             id_sr1,
    input  logic [2:0]             id_sr2,
    input  logic                   id_sr1_used,
    input  logic                   id_sr2_used,
    input  logic [2:0]             ex_dest,
    input  logic                   ex_mem_read,
    input  logic                   ex_regfile_write,
    input  logic [3:0]             mem_opcode,
    input  logic                   mem_access,
    input  logic                   dcache_resp,
    input  logic                   icache_resp,
    input  logic                   branch_taken,
    output logic                   load_pc,
    output logic                   load_if_id,
    output logic                   load_id_ex,
    output logic                   load_ex_mem,
    output logic                   load_mem_wb,
    output logic                   bubble_id_ex,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   flush_ex_mem,
    output logic                   ind_phase2,
    output logic                   load_ind_ptr,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [STALL_CNT_W-1:0] flush_count
);

    hazard_state_t r_state;
    hazard_state_t w_state_nxt;

    logic w_load_use;
    logic w_cache_stall;
    logic w_release;      // pipe is allowed to advance this cycle
    logic w_adv_front;    // PC and IF_ID
    logic w_adv_id_ex;
    logic w_adv_back;     // EX_MEM and MEM_WB
    logic w_bubble;
    logic w_flush;
    logic w_ind_phase2;
    logic w_load_ind_ptr;
    logic w_branch_act;

    pipeline_hazard_ctrl_load_use_detect u_load_use_detect (
        .i_id_sr1           (id_sr1),
        .i_id_sr2           (id_sr2),
        .i_id_sr1_used      (id_sr1_used),
        .i_id_sr2_used      (id_sr2_used),
        .i_ex_dest          (ex_dest),
        .i_ex_mem_read      (ex_mem_read),
        .i_ex_regfile_write (ex_regfile_write),
        .o_hazard           (w_load_use)
    );

    assign w_cache_stall = (mem_access && !dcache_resp) || !icache_resp;

    always_comb begin
        w_state_nxt    = r_state;
        w_release      = 1'b0;
        w_adv_front    = 1'b0;
        w_adv_id_ex    = 1'b0;
        w_adv_back     = 1'b0;
        w_bubble       = 1'b0;
        w_flush        = 1'b0;
        w_ind_phase2   = 1'b0;
        w_load_ind_ptr = 1'b0;
        w_branch_act   = 1'b0;

        if (reset) begin
            // Hold every register and clear the interstage registers so the
            // pipe restarts empty; any pending indirect is dropped.
            w_flush     = 1'b1;
            w_state_nxt = RUN;
        end else if (r_state == IND_WAIT2) begin
            // Second access uses the latched pointer until both caches
            // are done, then the whole pipe moves on together.
            w_ind_phase2 = 1'b1;
            if (dcache_resp && icache_resp) begin
                w_release   = 1'b1;
                w_state_nxt = RUN;
            end
        end else if (w_cache_stall) begin
            w_release = 1'b0;
        end else if (mem_access && dcache_resp && f_is_indirect(mem_opcode)) begin
            // First access returned the pointer: latch it and freeze MEM
            // for the second access.
            w_load_ind_ptr = 1'b1;
            w_state_nxt    = IND_WAIT2;
        end else begin
            w_release = 1'b1;
        end

        if (w_release) begin
            w_adv_back  = 1'b1;
            w_adv_id_ex = 1'b1;
            if (branch_taken) begin
                // The flush discards the younger instructions, including any
                // load-use consumer, so no bubble is needed.
                w_adv_front  = 1'b1;
                w_flush      = 1'b1;
                w_branch_act = 1'b1;
            end else if (w_load_use) begin
                // Hold IF and ID for one cycle; forwarding covers the rest.
                w_bubble = 1'b1;
            end else begin
                w_adv_front = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign load_pc      = w_adv_front;
    assign load_if_id   = w_adv_front;
    assign load_id_ex   = w_adv_id_ex;
    assign load_ex_mem  = w_adv_back;
    assign load_mem_wb  = w_adv_back;
    assign bubble_id_ex = w_bubble;
    assign flush_if_id  = w_flush;
    assign flush_id_ex  = w_flush;
    assign flush_ex_mem = w_flush;
    assign ind_phase2   = w_ind_phase2;
    assign load_ind_ptr = w_load_ind_ptr;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [STALL_CNT_W-1:0] c_CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic [STALL_CNT_W-1:0] r_flush_count;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_adv_front && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
            end
            if (w_branch_act && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + c_CNT_ONE;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

    // The ID opcode is carried for stage-register bookkeeping only.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, id_opcode};
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, id_opcode, w_branch_act};
`endif

endmodule
`default_nettype wire
